// File: rtl/food_spawner.sv
// Food placement for the 16x16 snake playfield: samples random positions, checks them against
// body occupancy over a req/ack port, and falls back to a linear scan after repeated rejects.
module food_spawner #(
  parameter int unsigned MAX_TRIES = 8,
  parameter logic [7:0]  INIT_POS  = 8'h88
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rnd_pos,
  input  logic       i_eaten,
  output logic       o_occ_req,
  output logic [7:0] o_occ_pos,
  input  logic       i_occ_ack,
  input  logic       i_occ_hit,
  output logic [7:0] o_food_pos,
  output logic       o_food_valid,
  output logic       o_board_full,
  output logic [7:0] o_spawn_count
);

  typedef enum logic [1:0] {StIdle, StSample, StReq, StFull} state_e;

  localparam logic [8:0] MaxTriesW = 9'(MAX_TRIES);
  localparam logic [8:0] ScanLast  = 9'd256;

  state_e     r_state, w_state_d;
  logic [7:0] r_cand, w_cand_d;
  logic [7:0] r_prev, w_prev_d;
  logic [7:0] r_tries, w_tries_d;
  logic [8:0] r_scan_cnt, w_scan_cnt_d;
  logic       r_scan_mode, w_scan_mode_d;
  logic [7:0] r_food_pos, w_food_pos_d;
  logic       r_food_valid, w_food_valid_d;
  logic [7:0] r_spawn_count, w_spawn_count_d;
  logic       r_occ_req, w_occ_req_d;
  logic       r_board_full, w_board_full_d;

  logic       w_accept;
  logic [8:0] w_tries_inc;

  // The cell just eaten is never re-offered, even if the body has moved off it.
  assign w_accept    = ~i_occ_hit & (r_cand != r_prev);
  assign w_tries_inc = {1'b0, r_tries} + 9'd1;

  always_comb begin
    w_state_d       = r_state;
    w_cand_d        = r_cand;
    w_prev_d        = r_prev;
    w_tries_d       = r_tries;
    w_scan_cnt_d    = r_scan_cnt;
    w_scan_mode_d   = r_scan_mode;
    w_food_pos_d    = r_food_pos;
    w_food_valid_d  = r_food_valid;
    w_spawn_count_d = r_spawn_count;

    unique case (r_state)
      StIdle: begin
        if (i_eaten) begin
          w_prev_d       = r_food_pos;
          w_food_valid_d = 1'b0;
          w_tries_d      = 8'd0;
          w_scan_cnt_d   = 9'd0;
          w_scan_mode_d  = 1'b0;
          w_state_d      = StSample;
        end
      end
      StSample: begin
        w_cand_d  = i_rnd_pos;
        w_state_d = StReq;
      end
      StReq: begin
        if (i_occ_ack) begin
          if (w_accept) begin
            w_food_pos_d    = r_cand;
            w_food_valid_d  = 1'b1;
            w_spawn_count_d = r_spawn_count + 8'd1;
            w_state_d       = StIdle;
          end else if (!r_scan_mode) begin
            w_tries_d = w_tries_inc[7:0];
            if (w_tries_inc < MaxTriesW) begin
              w_state_d = StSample;
            end else begin
              w_scan_mode_d = 1'b1;
              w_cand_d      = r_cand + 8'd1;
              w_scan_cnt_d  = 9'd1;
            end
          end else begin
            // scan_cnt numbers the pending scan query; the 256th reject covers every cell.
            w_cand_d     = r_cand + 8'd1;
            w_scan_cnt_d = r_scan_cnt + 9'd1;
            if (r_scan_cnt == ScanLast) begin
              w_state_d = StFull;
            end
          end
        end
      end
      StFull: begin
        w_food_valid_d = 1'b0;
      end
      default: w_state_d = StIdle;
    endcase

    w_occ_req_d    = (w_state_d == StReq);
    w_board_full_d = (w_state_d == StFull);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StIdle;
      r_cand        <= 8'd0;
      r_prev        <= 8'd0;
      r_tries       <= 8'd0;
      r_scan_cnt    <= 9'd0;
      r_scan_mode   <= 1'b0;
      r_food_pos    <= INIT_POS;
      r_food_valid  <= 1'b1;
      r_spawn_count <= 8'd0;
      r_occ_req     <= 1'b0;
      r_board_full  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cand        <= w_cand_d;
      r_prev        <= w_prev_d;
      r_tries       <= w_tries_d;
      r_scan_cnt    <= w_scan_cnt_d;
      r_scan_mode   <= w_scan_mode_d;
      r_food_pos    <= w_food_pos_d;
      r_food_valid  <= w_food_valid_d;
      r_spawn_count <= w_spawn_count_d;
      r_occ_req     <= w_occ_req_d;
      r_board_full  <= w_board_full_d;
    end
  end

  // r_cand is reset to zero, so the query address reads 0 out of reset.
  assign o_occ_req     = r_occ_req;
  assign o_occ_pos     = r_cand;
  assign o_food_pos    = r_food_pos;
  assign o_food_valid  = r_food_valid;
  assign o_board_full  = r_board_full;
  assign o_spawn_count = r_spawn_count;

endmodule

// File: doc/food_spawner.md
# food_spawner

Places the snake's food on the 16x16 playfield. The block sits directly downstream of the free-running pseudo-random position generator: it samples the generator's 8-bit position word when the current food has been eaten, checks the candidate against the snake-body occupancy store through a request/acknowledge port, and publishes an accepted food position to the renderer and collision logic. Repeated rejections switch it to a deterministic linear scan, so a free cell is always found if one exists.

## Interface

Parameters:
- `MAX_TRIES`, default 8: random candidates tried before switching to scan mode. Legal range 1..255.
- `INIT_POS`, default 8'h88: food position after reset.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low. 0 = reset.
- `rnd_pos`  in  8  raw position from the random generator, treated as {row[3:0], col[3:0]}; any value is legal.
- `eaten`  in  1  head hit the food; level, acted on only in IDLE.
- `occ_req`  out  1  occupancy query valid.
- `occ_pos`  out  8  cell being queried; stable while `occ_req`=1.
- `occ_ack`  in  1  occupancy response valid.
- `occ_hit`  in  1  cell occupied by body; qualified by `occ_ack`.
- `food_pos`  out  8  current food cell; valid when `food_valid`=1.
- `food_valid`  out  1  food present on board.
- `board_full`  out  1  no free cell exists; sticky until reset.
- `spawn_count`  out  8  number of successful spawns, wraps 255->0.

## Operation

- States: IDLE, SAMPLE, REQ, FULL. Internal registers: `cand`[7:0], `prev`[7:0], `tries`[7:0], `scan_cnt`[8:0], `scan_mode`.
- Reset (`rst`=0 at an edge): state IDLE, `food_pos`=INIT_POS, `food_valid`=1, `occ_req`=0, `occ_pos`=0, `board_full`=0, `spawn_count`=0, all internal counters and `scan_mode` 0. Reset overrides everything, including an in-progress query or FULL.
- IDLE: `eaten`=1 -> `prev`<=`food_pos`, `food_valid`<=0, `tries`<=0, `scan_cnt`<=0, `scan_mode`<=0, go to SAMPLE.
- SAMPLE: `cand`<=`rnd_pos`, go to REQ.
- REQ: `occ_req`=1, `occ_pos`=`cand`. The block waits in REQ indefinitely until `occ_ack`=1. In the `occ_ack` cycle:
  - Accept if `occ_hit`=0 and `cand`!=`prev`. Then `food_pos`<=`cand`, `food_valid`<=1, `spawn_count`<=`spawn_count`+1, go to IDLE.
  - Otherwise reject.
    - In random mode, `tries`<=`tries`+1. If `tries`+1 < MAX_TRIES, go to SAMPLE. Otherwise `scan_mode`<=1, `cand`<=`cand`+1 (mod 256), `scan_cnt`<=1, and stay in REQ.
    - In scan mode, `cand`<=`cand`+1 (mod 256), `scan_cnt`<=`scan_cnt`+1, and stay in REQ. When `scan_cnt` reaches 256 on a reject, go to FULL.
- FULL: `board_full`=1, `food_valid`=0, `occ_req`=0. The block stays in FULL until reset.
- `eaten` is ignored in SAMPLE, REQ and FULL.
- `occ_ack` outside REQ is ignored.
- `occ_hit` without `occ_ack` is ignored.

## Timing

- Minimum latency, with a zero-wait acknowledge: `eaten` sampled at edge E -> `food_valid` low after E -> `cand` latched at E+1 -> `occ_req` high during cycle E+1..E+2 -> accept at E+2 -> `food_valid`=1 after E+2.
- The `rnd_pos` value used is the one present at edge E+1.
- `occ_req` is registered. It deasserts in the cycle after the acknowledged cycle whenever the next state is not REQ.
  - On a scan-mode reject it stays high and `occ_pos` advances by one each acknowledge.
  - A single-cycle `occ_req` pulse is legal when the acknowledge arrives in the first REQ cycle.
- `food_pos` changes only on an accept edge or on reset.
- `spawn_count` increments on the same edge that `food_valid` rises.
- The worst case before FULL is MAX_TRIES random queries followed by 256 scan queries.

## Test plan

- Reset and idle: drive `rst`=0 for 2 cycles, then 1. Required: `food_pos`=8'h88, `food_valid`=1, `spawn_count`=0, `occ_req`=0, `board_full`=0.
- Clean spawn: pulse `eaten` with `rnd_pos`=8'h3C and the acknowledge returning `occ_hit`=0 in the first REQ cycle. Required: `occ_pos`=8'h3C, `food_valid` back high 3 cycles after `eaten`, `food_pos`=8'h3C, `spawn_count`=1.
- Same-cell and occupied rejection: `prev`=8'h3C; the first sample is 8'h3C, the second is 8'h51 with `occ_hit`=1, the third is 8'h52 with a free acknowledge. Required: 3 queries, `food_pos`=8'h52.
- Scan fallback: MAX_TRIES=8, every random candidate occupied, the last candidate 8'hFE, and cells 8'hFF and 8'h00 occupied. Required: scan queries 8'hFF, then 8'h00, then 8'h01 (wrap); accept at 8'h01; `occ_req` held high across the scan.
- Board full: the occupancy model reports every cell occupied. Required: FULL entered after 8+256 queries, `board_full`=1, `food_valid`=0, and a later `eaten` has no effect.
- Reset mid-query with stalled acknowledge: hold `occ_req` high with no acknowledge for 5 cycles, then assert reset. Required: `occ_req`=0 and outputs equal reset values on the next edge. Also check `spawn_count` wraps 255->0 after 256 spawns.
